vga_plot_arbiter: RTL and testbench
===================================

# vga_plot_arbiter

Shares the single VGA pixel-plot port (`VGA_X`, `VGA_Y`, `VGA_COLOR`, `plot`) between two independent pixel requesters and an optional full-screen clear engine.
- Each accepted request produces exactly one registered, one-cycle `plot` pulse with its coordinates and colour.
- The block sits between user drawing logic and the simulator's VGA sink in the DE-series `top` design.

## Interface
Parameters:
- `XW`, 8, column width
- `YW`, 7, row width
- `CW`, 3, colour width
- `XMAX`, 160, number of columns; valid x is 0..XMAX-1
- `YMAX`, 120, number of rows; valid y is 0..YMAX-1

Ports:
- `Clock` in 1: single clock, rising edge.
- `Resetn` in 1: asynchronous, active-low reset.
- `req0` in 1: requester 0 holds a pixel request.
- `x0` in XW, `y0` in YW, `c0` in CW: requester 0 pixel. Held stable while `req0` is high.
- `ack0` out 1: one-cycle accept for requester 0.
- `req1`, `x1`, `y1`, `c1` in; `ack1` out: same as requester 0, for requester 1.
- `clear` in 1: start a full-screen fill, sampled in IDLE.
- `clear_color` in CW: fill colour, sampled with `clear`.
- `busy` out 1: clear in progress.
- `done` out 1: one-cycle pulse when the clear finishes.
- `VGA_X` out XW, `VGA_Y` out YW, `VGA_COLOR` out CW, `plot` out 1: plot port; all registered.

## Operation
- Reset: state IDLE. `ack0`, `ack1`, `busy`, `done`, `plot` = 0. `VGA_X`, `VGA_Y`, `VGA_COLOR` = 0. `last` (last granted requester) = 1. Clear counters = 0.
- States are IDLE and CLEAR.
- IDLE, evaluated at each edge in priority order:
  1. `clear`=1: go to CLEAR. Latch `clear_color`; set x=0, y=0, `busy`=1. No ack this cycle.
  2. Otherwise, among requesters with req=1 and ack currently 0, grant one:
     - Only one eligible: grant it.
     - Both eligible: grant the one not equal to `last` (round-robin), then update `last`.
- On grant at edge E, during the following cycle:
  - `ackN`=1.
  - If x<XMAX and y<YMAX: `plot`=1 and `VGA_*` = that requester's x, y, colour.
  - Otherwise: `plot`=0 and `VGA_*` hold their previous values. The request is acked and dropped.
- A requester whose ack is high is ineligible that edge, so no double grant. The requester changes or drops req after seeing ack.
- CLEAR:
  - Each edge outputs `plot`=1 with the current (x, y, latched colour), then increments x.
  - When x wraps from XMAX-1 to 0, y increments.
  - After (XMAX-1, YMAX-1) is issued, at the same edge: `done`=1 for one cycle, `busy`=0, state = IDLE.
  - `clear`, `req0`, `req1` are ignored during CLEAR. Requests stay pending, unacked.
- Reset mid-operation aborts any clear immediately and applies reset values. No `done` is pulsed.

## Timing
- Request to plot latency: 1 cycle. `ack` and `plot` are coincident.
- Throughput:
  - One plot per cycle when both requesters alternate.
  - One plot per 2 cycles for a single continuous requester.
- `clear` sampled at E0 gives `busy`=1 from E0.
- Pixel (0,0) is plotted in the cycle after E1. The last pixel is plotted after edge E(XMAX·YMAX), with `done` coincident.
- A full clear of 160×120 takes 19200 plot cycles.
- Pending requests become eligible at the edge following `done`.

## Configuration
- `VGA_PLOT_CLEAR_EN` defined: CLEAR state, counters, `busy`/`done` logic are present as described.
- Not defined:
  - No CLEAR state.
  - `clear` and `clear_color` are ignored.
  - `busy` and `done` are tied 0.
  - IDLE arbitration is the only behaviour.

## Test plan
- Reset with `Resetn`=0 while `req0`=1: all outputs 0. After release, `req0` with (5,7,3) gives `ack0`=1, `plot`=1, `VGA_X`=5, `VGA_Y`=7, `VGA_COLOR`=3 in the cycle after the sampling edge.
- `req0` and `req1` held high continuously: grants alternate 0,1,0,1, starting with requester 0. One `plot` per cycle. No requester acked on consecutive cycles.
- `req1` with x=160, y=10: `ack1`=1, `plot`=0, `VGA_*` unchanged.
- `clear`=1 with colour 5 (macro defined): `busy` high, exactly 19200 plot pulses covering (0,0)..(159,119) in raster order, all colour 5. `done` is coincident with (159,119). `req0` asserted mid-clear is acked only the cycle after `done`.
- Reset asserted at pixel 1000 of a clear: `busy`, `plot`=0 at once, no `done`. A subsequent clear restarts at (0,0).
- Macro undefined: `clear`=1 gives `busy`=0, no plot pulses, and requests are still served in the same cycle window.

Source files
------------

// File: rtl/vga_plot_arbiter.sv
// vga_plot_arbiter: shares one registered VGA plot port between two pixel
// requesters (round-robin) and an optional full-screen clear engine.
// Optional feature macro: VGA_PLOT_CLEAR_EN enables the CLEAR state, the
// raster counters and the busy/done handshake. When it is undefined the
// block only arbitrates, and busy/done are tied low.
module vga_plot_arbiter #(
  parameter int XW   = 8,
  parameter int YW   = 7,
  parameter int CW   = 3,
  parameter int XMAX = 160,
  parameter int YMAX = 120
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          req0,
  input  logic [XW-1:0] x0,
  input  logic [YW-1:0] y0,
  input  logic [CW-1:0] c0,
  output logic          ack0,
  input  logic          req1,
  input  logic [XW-1:0] x1,
  input  logic [YW-1:0] y1,
  input  logic [CW-1:0] c1,
  output logic          ack1,
  input  logic          clear,
  input  logic [CW-1:0] clear_color,
  output logic          busy,
  output logic          done,
  output logic [XW-1:0] VGA_X,
  output logic [YW-1:0] VGA_Y,
  output logic [CW-1:0] VGA_COLOR,
  output logic          plot
);

  typedef logic [XW-1:0] x_t;
  typedef logic [YW-1:0] y_t;
  typedef logic [XW:0]   xl_t;
  typedef logic [YW:0]   yl_t;

  // One extra bit so XMAX/YMAX themselves are representable in the limit.
  localparam xl_t X_LIM = xl_t'(XMAX);
  localparam yl_t Y_LIM = yl_t'(YMAX);

  // Registered plot port and handshake state
  logic          r_ack0, r_ack1, r_plot, r_last;
  x_t            r_vga_x;
  y_t            r_vga_y;
  logic [CW-1:0] r_vga_c;

  logic          w_ack0_nxt, w_ack1_nxt, w_plot_nxt, w_last_nxt;
  x_t            w_vga_x_nxt;
  y_t            w_vga_y_nxt;
  logic [CW-1:0] w_vga_c_nxt;

  logic          w_arb_en;
  logic          w_elig0, w_elig1, w_grant0, w_grant1;
  logic          w_in_range0, w_in_range1;

`ifdef VGA_PLOT_CLEAR_EN
  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  localparam x_t X_LAST = x_t'(XMAX - 1);
  localparam y_t Y_LAST = y_t'(YMAX - 1);

  state_t        r_state, w_state_nxt;
  x_t            r_cx, w_cx_nxt;
  y_t            r_cy, w_cy_nxt;
  logic [CW-1:0] r_ccol, w_ccol_nxt;
  logic          r_busy, w_busy_nxt;
  logic          r_done, w_done_nxt;
`else
  // The clear inputs have no function in this build.
  logic w_unused_clear;
  assign w_unused_clear = ^{clear, clear_color};
`endif

  // A requester whose ack is already high cannot win again this edge, so a
  // held request is never granted twice in a row.
  assign w_elig0 = req0 & ~r_ack0;
  assign w_elig1 = req1 & ~r_ack1;

  // Round-robin: on a tie, grant the requester that was not granted last.
  assign w_grant0 = w_elig0 & (~w_elig1 | r_last);
  assign w_grant1 = w_elig1 & (~w_elig0 | ~r_last);

  assign w_in_range0 = ({1'b0, x0} < X_LIM) && ({1'b0, y0} < Y_LIM);
  assign w_in_range1 = ({1'b0, x1} < X_LIM) && ({1'b0, y1} < Y_LIM);

  // Next-state and next-output logic for arbitration and clear sequencing
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch; blocking '=' is correct here.
    w_ack0_nxt  = 1'b0;
    w_ack1_nxt  = 1'b0;
    w_plot_nxt  = 1'b0;
    w_last_nxt  = r_last;
    w_vga_x_nxt = r_vga_x;
    w_vga_y_nxt = r_vga_y;
    w_vga_c_nxt = r_vga_c;
`ifdef VGA_PLOT_CLEAR_EN
    w_arb_en    = 1'b0;
    w_state_nxt = r_state;
    w_cx_nxt    = r_cx;
    w_cy_nxt    = r_cy;
    w_ccol_nxt  = r_ccol;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;

    case (r_state)
      S_CLEAR: begin
        // Issue the current raster pixel, then advance in raster order.
        w_plot_nxt  = 1'b1;
        w_vga_x_nxt = r_cx;
        w_vga_y_nxt = r_cy;
        w_vga_c_nxt = r_ccol;
        if (r_cx == X_LAST) begin
          w_cx_nxt = '0;
          if (r_cy == Y_LAST) begin
            w_cy_nxt    = '0;
            w_done_nxt  = 1'b1;
            w_busy_nxt  = 1'b0;
            w_state_nxt = S_IDLE;
          end else begin
            w_cy_nxt = r_cy + y_t'(1);
          end
        end else begin
          w_cx_nxt = r_cx + x_t'(1);
        end
      end
      default: begin
        if (clear) begin
          w_state_nxt = S_CLEAR;
          w_ccol_nxt  = clear_color;
          w_cx_nxt    = '0;
          w_cy_nxt    = '0;
          w_busy_nxt  = 1'b1;
        end else begin
          w_arb_en = 1'b1;
        end
      end
    endcase
`else
    w_arb_en = 1'b1;
`endif

    if (w_arb_en) begin
      if (w_grant0) begin
        w_ack0_nxt = 1'b1;
        w_last_nxt = 1'b0;
        if (w_in_range0) begin
          w_plot_nxt  = 1'b1;
          w_vga_x_nxt = x0;
          w_vga_y_nxt = y0;
          w_vga_c_nxt = c0;
        end
      end else if (w_grant1) begin
        w_ack1_nxt = 1'b1;
        w_last_nxt = 1'b1;
        if (w_in_range1) begin
          w_plot_nxt  = 1'b1;
          w_vga_x_nxt = x1;
          w_vga_y_nxt = y1;
          w_vga_c_nxt = c1;
        end
      end
    end
  end

  // Register the plot port, handshakes and arbitration history
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      r_plot  <= 1'b0;
      r_last  <= 1'b1;
      r_vga_x <= '0;
      r_vga_y <= '0;
      r_vga_c <= '0;
    end else begin
      // NOTE: non-blocking '<=' so every register samples pre-edge values.
      r_ack0  <= w_ack0_nxt;
      r_ack1  <= w_ack1_nxt;
      r_plot  <= w_plot_nxt;
      r_last  <= w_last_nxt;
      r_vga_x <= w_vga_x_nxt;
      r_vga_y <= w_vga_y_nxt;
      r_vga_c <= w_vga_c_nxt;
    end
  end

`ifdef VGA_PLOT_CLEAR_EN
  // Register the clear engine state; reset aborts a fill with no done pulse
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state <= S_IDLE;
      r_cx    <= '0;
      r_cy    <= '0;
      r_ccol  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cx    <= w_cx_nxt;
      r_cy    <= w_cy_nxt;
      r_ccol  <= w_ccol_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign busy = r_busy;
  assign done = r_done;
`else
  assign busy = 1'b0;
  assign done = 1'b0;
`endif

  assign ack0      = r_ack0;
  assign ack1      = r_ack1;
  assign plot      = r_plot;
  assign VGA_X     = r_vga_x;
  assign VGA_Y     = r_vga_y;
  assign VGA_COLOR = r_vga_c;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Self-checking bench for vga_plot_arbiter: randomized requesters checked
// cycle by cycle against a behavioural model, plus directed scenarios.
// Clear-engine scenarios follow the VGA_PLOT_CLEAR_EN macro.
module tb_vga_plot_arbiter;

  localparam int XW   = 8;
  localparam int YW   = 7;
  localparam int CW   = 3;
  localparam int XMAX = 160;
  localparam int YMAX = 120;
  localparam int NPIX = XMAX * YMAX;

  typedef logic [XW-1:0] x_t;
  typedef logic [YW-1:0] y_t;
  typedef logic [CW-1:0] c_t;
  typedef logic [4+XW+YW+CW:0] vec_t;

  logic Clock = 1'b0;
  logic Resetn;
  logic req0, req1, clear;
  x_t   x0, x1;
  y_t   y0, y1;
  c_t   c0, c1, clear_color;
  logic ack0, ack1, busy, done, plot;
  x_t   VGA_X;
  y_t   VGA_Y;
  c_t   VGA_COLOR;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clock = ~Clock;

  vga_plot_arbiter #(.XW(XW), .YW(YW), .CW(CW), .XMAX(XMAX), .YMAX(YMAX)) dut (
    .Clock(Clock), .Resetn(Resetn),
    .req0(req0), .x0(x0), .y0(y0), .c0(c0), .ack0(ack0),
    .req1(req1), .x1(x1), .y1(y1), .c1(c1), .ack1(ack1),
    .clear(clear), .clear_color(clear_color), .busy(busy), .done(done),
    .VGA_X(VGA_X), .VGA_Y(VGA_Y), .VGA_COLOR(VGA_COLOR), .plot(plot)
  );

  // ---------------- behavioural model ----------------
  bit m_last, m_ack0, m_ack1, m_plot, m_busy, m_done, m_clearing;
  x_t m_x;
  y_t m_y;
  c_t m_c, m_ccol;
  int m_pix;

  function automatic vec_t dut_vec();
    return {ack0, ack1, plot, busy, done, VGA_X, VGA_Y, VGA_COLOR};
  endfunction

  function automatic vec_t exp_vec();
    return {m_ack0, m_ack1, m_plot, m_busy, m_done, m_x, m_y, m_c};
  endfunction

  task automatic model_reset();
    m_last = 1'b1; m_ack0 = 0; m_ack1 = 0; m_plot = 0; m_busy = 0; m_done = 0;
    m_clearing = 0; m_x = '0; m_y = '0; m_c = '0; m_ccol = '0; m_pix = 0;
  endtask

  task automatic model_edge();
    int g;
    bit e0, e1;
    m_done = 0;
    if (m_clearing) begin
      // Pixel index m_pix walks the screen in raster order.
      m_ack0 = 0; m_ack1 = 0; m_plot = 1;
      m_x = x_t'(m_pix % XMAX);
      m_y = y_t'(m_pix / XMAX);
      m_c = m_ccol;
      m_pix++;
      if (m_pix == NPIX) begin
        m_done = 1; m_busy = 0; m_clearing = 0;
      end
`ifdef VGA_PLOT_CLEAR_EN
    end else if (clear) begin
      m_clearing = 1; m_pix = 0; m_ccol = clear_color; m_busy = 1;
      m_ack0 = 0; m_ack1 = 0; m_plot = 0;
`endif
    end else begin
      e0 = req0 && !m_ack0;
      e1 = req1 && !m_ack1;
      g = -1;
      if (e0 && e1) g = m_last ? 0 : 1;
      else if (e0)  g = 0;
      else if (e1)  g = 1;
      m_ack0 = (g == 0);
      m_ack1 = (g == 1);
      m_plot = 0;
      if (g == 0) begin
        m_last = 0;
        if (int'(x0) < XMAX && int'(y0) < YMAX) begin
          m_plot = 1; m_x = x0; m_y = y0; m_c = c0;
        end
      end else if (g == 1) begin
        m_last = 1;
        if (int'(x1) < XMAX && int'(y1) < YMAX) begin
          m_plot = 1; m_x = x1; m_y = y1; m_c = c1;
        end
      end
    end
  endtask

  // Advance one clock: model follows the edge, outputs settle by negedge.
  task automatic step();
    @(posedge Clock);
    model_edge();
    @(negedge Clock);
  endtask

  // Hold reset across one rising edge; called at a falling edge.
  task automatic do_reset();
    #2 Resetn = 1'b0;
    model_reset();
    @(negedge Clock);
    Resetn = 1'b1;
  endtask

  task automatic new_pix(output x_t x, output y_t y, output c_t c);
    x = ($urandom_range(7) == 0) ? x_t'($urandom_range(255, XMAX)) : x_t'($urandom_range(XMAX - 1));
    y = ($urandom_range(7) == 0) ? y_t'($urandom_range(127, YMAX)) : y_t'($urandom_range(YMAX - 1));
    c = c_t'($urandom);
  endtask

  // Requesters keep a request stable until acked, then drop or replace it.
  task automatic rand_reqs();
    if (m_ack0 || (!req0 && $urandom_range(99) < 60)) begin
      req0 = ($urandom_range(99) < 70);
      new_pix(x0, y0, c0);
    end
    if (m_ack1 || (!req1 && $urandom_range(99) < 60)) begin
      req1 = ($urandom_range(99) < 70);
      new_pix(x1, y1, c1);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    Resetn = 1'b0; model_reset();
    req0 = 1'b1; x0 = 8'd5; y0 = 7'd7; c0 = 3'd3;
    repeat (2) @(negedge Clock);
    n_checks++;
    if (dut_vec() !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %h want 0", dut_vec());
    end
    Resetn = 1'b1;
    step();
    n_checks++;
    if ({ack0, ack1, plot, VGA_X, VGA_Y, VGA_COLOR} !== {1'b1, 1'b0, 1'b1, 8'd5, 7'd7, 3'd3}) begin
      n_fail++;
      $display("FAIL first_grant: ack0=%b ack1=%b plot=%b xyc=%0d,%0d,%0d want 1 0 1 5,7,3",
               ack0, ack1, plot, VGA_X, VGA_Y, VGA_COLOR);
    end
    req0 = 1'b0;
    step();
    n_checks++;
    if ({ack0, ack1, plot} !== 3'b000) begin
      n_fail++; $display("FAIL idle_after_grant: ack0=%b ack1=%b plot=%b want 000", ack0, ack1, plot);
    end
  endtask

  task automatic test_alternate();
    req0 = 0; req1 = 0;
    do_reset();
    req0 = 1; x0 = 8'd20; y0 = 7'd30; c0 = 3'd1;
    req1 = 1; x1 = 8'd40; y1 = 7'd50; c1 = 3'd2;
    for (int k = 1; k <= 20; k++) begin
      step();
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL alternate_model cyc %0d: got %h want %h", k, dut_vec(), exp_vec());
      end
      n_checks++;
      if ({ack0, ack1, plot} !== {(k % 2 == 1), (k % 2 == 0), 1'b1}) begin
        n_fail++;
        $display("FAIL alternate_grant cyc %0d: ack0=%b ack1=%b plot=%b want %b %b 1",
                 k, ack0, ack1, plot, k % 2 == 1, k % 2 == 0);
      end
    end
    req0 = 0; req1 = 0;
    step();
  endtask

  task automatic test_out_of_range();
    do_reset();
    req0 = 1; x0 = 8'd10; y0 = 7'd20; c0 = 3'd1;
    step();
    req0 = 0;
    req1 = 1; x1 = 8'd160; y1 = 7'd10; c1 = 3'd6;
    step();
    n_checks++;
    if ({ack1, plot, VGA_X, VGA_Y, VGA_COLOR} !== {1'b1, 1'b0, 8'd10, 7'd20, 3'd1}) begin
      n_fail++;
      $display("FAIL x_out_of_range: ack1=%b plot=%b xyc=%0d,%0d,%0d want 1 0 10,20,1",
               ack1, plot, VGA_X, VGA_Y, VGA_COLOR);
    end
    req1 = 0;
    req0 = 1; x0 = 8'd5; y0 = 7'd120; c0 = 3'd2;
    step();
    n_checks++;
    if ({ack0, plot, VGA_X, VGA_Y, VGA_COLOR} !== {1'b1, 1'b0, 8'd10, 7'd20, 3'd1}) begin
      n_fail++;
      $display("FAIL y_out_of_range: ack0=%b plot=%b xyc=%0d,%0d,%0d want 1 0 10,20,1",
               ack0, plot, VGA_X, VGA_Y, VGA_COLOR);
    end
    req0 = 0;
    req1 = 1; x1 = 8'd159; y1 = 7'd119; c1 = 3'd7;
    step();
    n_checks++;
    if ({ack1, plot, VGA_X, VGA_Y, VGA_COLOR} !== {1'b1, 1'b1, 8'd159, 7'd119, 3'd7}) begin
      n_fail++;
      $display("FAIL corner_in_range: ack1=%b plot=%b xyc=%0d,%0d,%0d want 1 1 159,119,7",
               ack1, plot, VGA_X, VGA_Y, VGA_COLOR);
    end
    req1 = 0;
    step();
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 600; k++) begin
      rand_reqs();
      step();
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL random cyc %0d: got %h want %h", k, dut_vec(), exp_vec());
      end
    end
    req0 = 0; req1 = 0;
    step();
  endtask

`ifdef VGA_PLOT_CLEAR_EN
  task automatic test_clear();
    int  n_plots;
    bit  got_done;
    n_plots = 0; got_done = 0;
    do_reset();
    clear = 1; clear_color = 3'd5;
    step();
    clear = 0;
    n_checks++;
    if ({busy, plot, ack0, ack1} !== 4'b1000) begin
      n_fail++; $display("FAIL clear_start: busy=%b plot=%b ack=%b%b want 1 0 00", busy, plot, ack0, ack1);
    end
    for (int k = 1; k <= NPIX + 50; k++) begin
      if (k == 1000) begin
        req0 = 1; x0 = 8'd9; y0 = 7'd9; c0 = 3'd2;
      end
      step();
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL clear_model cyc %0d: got %h want %h", k, dut_vec(), exp_vec());
      end
      if (plot) n_plots++;
      if (done) begin
        got_done = 1;
        n_checks++;
        if ({n_plots, VGA_X, VGA_Y, VGA_COLOR, busy} !== {NPIX, 8'd159, 7'd119, 3'd5, 1'b0}) begin
          n_fail++;
          $display("FAIL clear_done: plots=%0d xyc=%0d,%0d,%0d busy=%b want %0d 159,119,5 0",
                   n_plots, VGA_X, VGA_Y, VGA_COLOR, busy, NPIX);
        end
        break;
      end
    end
    n_checks++;
    if (!got_done) begin
      n_fail++; $display("FAIL clear_timeout: done=0 want 1 within %0d cycles", NPIX + 50);
    end
    step();
    n_checks++;
    if ({ack0, plot, busy, done, VGA_X, VGA_Y, VGA_COLOR} !== {1'b1, 1'b1, 1'b0, 1'b0, 8'd9, 7'd9, 3'd2}) begin
      n_fail++;
      $display("FAIL pending_after_done: ack0=%b plot=%b busy=%b done=%b xyc=%0d,%0d,%0d want 1 1 0 0 9,9,2",
               ack0, plot, busy, done, VGA_X, VGA_Y, VGA_COLOR);
    end
    req0 = 0;
    step();
  endtask

  task automatic test_clear_reset();
    do_reset();
    clear = 1; clear_color = 3'd6;
    step();
    clear = 0;
    for (int k = 0; k < 1001; k++) begin
      step();
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL clear_abort_model cyc %0d: got %h want %h", k, dut_vec(), exp_vec());
      end
    end
    #2 Resetn = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({busy, plot, done} !== 3'b000) begin
      n_fail++; $display("FAIL reset_abort: busy=%b plot=%b done=%b want 000", busy, plot, done);
    end
    @(negedge Clock);
    Resetn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL after_abort cyc %0d: got %h want %h", k, dut_vec(), exp_vec());
      end
    end
    clear = 1; clear_color = 3'd2;
    step();
    clear = 0;
    step();
    n_checks++;
    if ({plot, busy, VGA_X, VGA_Y, VGA_COLOR} !== {1'b1, 1'b1, 8'd0, 7'd0, 3'd2}) begin
      n_fail++;
      $display("FAIL clear_restart: plot=%b busy=%b xyc=%0d,%0d,%0d want 1 1 0,0,2",
               plot, busy, VGA_X, VGA_Y, VGA_COLOR);
    end
    for (int k = 0; k < 200; k++) begin
      step();
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL restart_model cyc %0d: got %h want %h", k, dut_vec(), exp_vec());
      end
    end
    do_reset();
  endtask
`else
  task automatic test_clear();
    do_reset();
    clear = 1; clear_color = 3'd5;
    req0 = 1; x0 = 8'd3; y0 = 7'd4; c0 = 3'd6;
    step();
    n_checks++;
    if ({ack0, plot, busy, done, VGA_X, VGA_Y, VGA_COLOR} !== {1'b1, 1'b1, 1'b0, 1'b0, 8'd3, 7'd4, 3'd6}) begin
      n_fail++;
      $display("FAIL clear_ignored_grant: ack0=%b plot=%b busy=%b done=%b xyc=%0d,%0d,%0d want 1 1 0 0 3,4,6",
               ack0, plot, busy, done, VGA_X, VGA_Y, VGA_COLOR);
    end
    req0 = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      n_checks++;
      if ({ack0, ack1, plot, busy, done} !== 5'b00000) begin
        n_fail++;
        $display("FAIL clear_ignored_idle cyc %0d: ack=%b%b plot=%b busy=%b done=%b want 00000",
                 k, ack0, ack1, plot, busy, done);
      end
    end
    clear = 0;
    step();
  endtask

  task automatic test_clear_reset();
    // No clear engine in this build; reset behaviour is covered elsewhere.
    do_reset();
  endtask
`endif

  initial begin
    Resetn = 1'b0;
    req0 = 0; req1 = 0; clear = 0; clear_color = '0;
    x0 = '0; y0 = '0; c0 = '0; x1 = '0; y1 = '0; c1 = '0;
    model_reset();
    @(negedge Clock);
    test_reset();
    test_alternate();
    test_out_of_range();
    test_random();
    test_clear();
    test_clear_reset();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
